// File: rtl/tpu_result_collector.sv
// Captures the TPU A/B/C result writes into per-channel banks and streams all three banks out as 32-bit valid/ready beats.
// Start latency is 2 cycles, and beats hold while rd_ready is low. `AUTO_DUMP_EN starts a dump on a tpu_done rising edge.
module tpu_result_collector #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128,
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              sram_write_enable_a0,
  input  logic              sram_write_enable_b0,
  input  logic              sram_write_enable_c0,
  input  logic [ADDR_W-1:0] sram_waddr_a,
  input  logic [ADDR_W-1:0] sram_waddr_b,
  input  logic [ADDR_W-1:0] sram_waddr_c,
  input  logic [DATA_W-1:0] sram_wdata_a,
  input  logic [DATA_W-1:0] sram_wdata_b,
  input  logic [DATA_W-1:0] sram_wdata_c,
  input  logic              tpu_done,
  input  logic              rd_start,
  input  logic              clr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [BEAT_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic [2:0]        wr_seen,
  output logic              wr_during_rd
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BEATS = DATA_W / BEAT_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem_a [DEPTH];
  logic [DATA_W-1:0]   r_mem_b [DEPTH];
  logic [DATA_W-1:0]   r_mem_c [DEPTH];
  logic [DEPTH-1:0]    r_vld_a;
  logic [DEPTH-1:0]    r_vld_b;
  logic [DEPTH-1:0]    r_vld_c;
  logic [2:0]          r_wr_seen;
  logic                r_wr_during_rd;
  logic [1:0]          r_bank;
  logic [ADDR_W-1:0]   r_addr;
  logic [BCW-1:0]      r_beat;
  logic [DATA_W-1:0]   r_line;
  logic                w_start;
  logic                w_idle;
  logic                w_hs;
  logic                w_beat_end;
  logic                w_final;
  logic [DATA_W-1:0]   w_fetch_dat;
  logic                w_fetch_vld;

`ifdef AUTO_DUMP_EN
  logic r_done_q;
  logic r_done_rise;

  // The rise is a one-cycle pulse, so an edge seen while busy is simply dropped.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_done_q    <= 1'b0;
      r_done_rise <= 1'b0;
    end else begin
      r_done_q    <= tpu_done;
      r_done_rise <= tpu_done & ~r_done_q;
    end
  end

  assign w_start = rd_start | r_done_rise;
`else
  logic w_unused_done;
  assign w_unused_done = tpu_done;
  assign w_start       = rd_start;
`endif

  assign w_idle     = (r_state == S_IDLE);
  assign w_hs       = rd_valid & rd_ready;
  assign w_beat_end = (r_beat == BCW'(BEATS - 1));
  assign w_final    = (r_bank == 2'd2) & (&r_addr) & w_beat_end;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_SEND;
      S_SEND:  if (w_hs && w_beat_end) w_state_nxt = w_final ? S_IDLE : S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_data  = '0;
    busy     = (r_state != S_IDLE);
    if (r_state == S_SEND) begin
      rd_valid = 1'b1;
      rd_last  = w_final;
      rd_data  = r_line[r_beat*BEAT_W +: BEAT_W];
    end
  end

  always_comb begin
    w_fetch_dat = '0;
    w_fetch_vld = 1'b0;
    case (r_bank)
      2'd0:    begin w_fetch_dat = r_mem_a[r_addr]; w_fetch_vld = r_vld_a[r_addr]; end
      2'd1:    begin w_fetch_dat = r_mem_b[r_addr]; w_fetch_vld = r_vld_b[r_addr]; end
      2'd2:    begin w_fetch_dat = r_mem_c[r_addr]; w_fetch_vld = r_vld_c[r_addr]; end
      default: begin w_fetch_dat = '0;              w_fetch_vld = 1'b0;            end
    endcase
  end

  // Bank storage has no reset; the valid bitmaps decide what is visible.
  always_ff @(posedge clk) begin
    if (sram_write_enable_a0) r_mem_a[sram_waddr_a] <= sram_wdata_a;
    if (sram_write_enable_b0) r_mem_b[sram_waddr_b] <= sram_wdata_b;
    if (sram_write_enable_c0) r_mem_c[sram_waddr_c] <= sram_wdata_c;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_vld_a        <= '0;
      r_vld_b        <= '0;
      r_vld_c        <= '0;
      r_wr_seen      <= 3'b000;
      r_wr_during_rd <= 1'b0;
    end else begin
      if (w_idle && clr) begin
        r_vld_a        <= '0;
        r_vld_b        <= '0;
        r_vld_c        <= '0;
        r_wr_seen      <= 3'b000;
        r_wr_during_rd <= 1'b0;
      end
      if (sram_write_enable_a0) begin
        r_vld_a[sram_waddr_a] <= 1'b1;
        r_wr_seen[0]          <= 1'b1;
      end
      if (sram_write_enable_b0) begin
        r_vld_b[sram_waddr_b] <= 1'b1;
        r_wr_seen[1]          <= 1'b1;
      end
      if (sram_write_enable_c0) begin
        r_vld_c[sram_waddr_c] <= 1'b1;
        r_wr_seen[2]          <= 1'b1;
      end
      if (!w_idle && (sram_write_enable_a0 || sram_write_enable_b0 || sram_write_enable_c0))
        r_wr_during_rd <= 1'b1;
    end
  end

  // Line register reads the bank before any same-edge write lands (read-first).
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_bank <= 2'd0;
      r_addr <= '0;
      r_beat <= '0;
      r_line <= '0;
    end else if (w_idle && w_start) begin
      r_bank <= 2'd0;
      r_addr <= '0;
      r_beat <= '0;
    end else if (r_state == S_FETCH) begin
      r_line <= w_fetch_vld ? w_fetch_dat : '0;
    end else if (r_state == S_SEND && w_hs) begin
      if (w_beat_end) begin
        r_beat <= '0;
        r_addr <= r_addr + 1'b1;
        if (&r_addr) r_bank <= r_bank + 2'd1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign wr_seen      = r_wr_seen;
  assign wr_during_rd = r_wr_during_rd;

endmodule

// File: tb/tb_tpu_result_collector.sv
// Directed, table-driven bench for tpu_result_collector: write vectors with hand-computed beats, plus dump corner sequences.
module tb_tpu_result_collector;

  logic         clk = 1'b0;
  logic         srst;
  logic         we_a, we_b, we_c;
  logic [5:0]   waddr_a, waddr_b, waddr_c;
  logic [127:0] wdata_a, wdata_b, wdata_c;
  logic         tpu_done, rd_start, clr, rd_ready;
  logic         rd_valid, rd_last, busy, wr_during_rd;
  logic [31:0]  rd_data;
  logic [2:0]   wr_seen;

  always #5 clk = ~clk;

  tpu_result_collector dut (
    .clk(clk), .srst(srst),
    .sram_write_enable_a0(we_a), .sram_write_enable_b0(we_b), .sram_write_enable_c0(we_c),
    .sram_waddr_a(waddr_a), .sram_waddr_b(waddr_b), .sram_waddr_c(waddr_c),
    .sram_wdata_a(wdata_a), .sram_wdata_b(wdata_b), .sram_wdata_c(wdata_c),
    .tpu_done(tpu_done), .rd_start(rd_start), .clr(clr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .wr_seen(wr_seen), .wr_during_rd(wr_during_rd)
  );

  typedef struct {
    int               bank;
    int               addr;
    logic [127:0]     data;
    bit               fin;
    int               phase;
    logic [3:0][31:0] eb;
  } vec_t;

  vec_t         vec [8];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [31:0]  got [768];
  logic [31:0]  ref_beats [768];
  logic [127:0] exp_mem [192];
  bit           exp_vld [192];
  int           d_beats, d_last_cnt, d_last_at, d_stall_err, d_first_valid, d_cycles, d_last_hs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int bank, input int addr, input logic [127:0] d);
    case (bank)
      0: begin we_a = 1'b1; waddr_a = 6'(addr); wdata_a = d; end
      1: begin we_b = 1'b1; waddr_b = 6'(addr); wdata_b = d; end
      default: begin we_c = 1'b1; waddr_c = 6'(addr); wdata_c = d; end
    endcase
    @(posedge clk); #1;
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    exp_mem[bank*64 + addr] = d;
    exp_vld[bank*64 + addr] = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 192; i++) exp_vld[i] = 1'b0;
  endtask

  task automatic do_dump(input bit rnd, input bit with_clr);
    bit          stall;
    logic [31:0] hd;
    logic        hl;
    int          cyc;
    rd_start = 1'b1; clr = with_clr;
    @(posedge clk); #1;
    rd_start = 1'b0; clr = 1'b0;
    d_beats = 0; d_last_cnt = 0; d_last_at = -1; d_stall_err = 0;
    d_first_valid = -1; d_last_hs = -1; stall = 1'b0; cyc = 0; hd = '0; hl = 1'b0;
    rd_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    while (busy && cyc < 6000) begin
      if (stall && (!rd_valid || rd_data !== hd || rd_last !== hl)) d_stall_err++;
      if (rd_last && !rd_valid) d_stall_err++;
      if (rd_valid && d_first_valid < 0) d_first_valid = cyc;
      stall = 1'b0;
      if (rd_valid && rd_ready) begin
        if (d_beats < 768) got[d_beats] = rd_data;
        if (rd_last) begin d_last_cnt++; d_last_at = d_beats; end
        d_beats++;
        d_last_hs = cyc;
      end else if (rd_valid) begin
        stall = 1'b1; hd = rd_data; hl = rd_last;
      end
      @(posedge clk); #1;
      cyc++;
      rd_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    d_cycles = cyc;
    rd_ready = 1'b1;
  endtask

  function automatic int content_bad();
    int           bad = 0;
    logic [127:0] t;
    logic [31:0]  e;
    for (int i = 0; i < 768; i++) begin
      t = exp_mem[i/4];
      e = exp_vld[i/4] ? t[(i%4)*32 +: 32] : 32'h0;
      if (got[i] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic check_dump(input string tag, input bit ready_high);
    check({tag, "_beats"}, d_beats, 768);
    check({tag, "_last_count"}, d_last_cnt, 1);
    check({tag, "_last_pos"}, d_last_at, 767);
    check({tag, "_first_valid_cyc"}, d_first_valid, 1);
    check({tag, "_busy_fall"}, d_cycles - d_last_hs, 1);
    check({tag, "_stall_hold"}, d_stall_err, 0);
    if (ready_high) check({tag, "_cycles"}, d_cycles, 960);
    check({tag, "_content_errs"}, content_bad(), 0);
  endtask

  task automatic check_table(input int p);
    int idx;
    for (int i = 0; i < 8; i++) begin
      if (vec[i].phase <= p && vec[i].fin) begin
        for (int k = 0; k < 4; k++) begin
          idx = (vec[i].bank*64 + vec[i].addr)*4 + k;
          check($sformatf("vec%0d_beat%0d", i, k), got[idx], vec[i].eb[k]);
        end
      end
    end
  endtask

  initial begin
    int hs, cyc, diffs, n;

    vec[0] = '{0,  0, 128'h00000004_00000003_00000002_00000001, 1'b1, 0, {32'h4, 32'h3, 32'h2, 32'h1}};
    vec[1] = '{2, 63, {128{1'b1}},                                1'b1, 0, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}};
    vec[2] = '{0, 63, 128'h80000000_00000000_00000000_00000001, 1'b1, 1, {32'h80000000, 32'h0, 32'h0, 32'h1}};
    vec[3] = '{1,  0, 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00, 1'b1, 1, {32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FF00FF, 32'hFF00FF00}};
    vec[4] = '{0, 10, 128'h11111111_22222222_33333333_44444444, 1'b0, 1, {32'h0, 32'h0, 32'h0, 32'h0}};
    vec[5] = '{0, 10, 128'h00000000_AAAAAAAA_00000000_55555555, 1'b1, 1, {32'h0, 32'hAAAAAAAA, 32'h0, 32'h55555555}};
    vec[6] = '{1,  5, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 1'b1, 2, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}};
    vec[7] = '{2,  2, 128'h00000007_00000006_00000005_00000000, 1'b1, 2, {32'h7, 32'h6, 32'h5, 32'h0}};

    model_clear();
    srst = 1'b1; we_a = 0; we_b = 0; we_c = 0;
    waddr_a = '0; waddr_b = '0; waddr_c = '0; wdata_a = '0; wdata_b = '0; wdata_c = '0;
    tpu_done = 0; rd_start = 0; clr = 0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_seen", wr_seen, 3'b000);
    check("rst_wr_during_rd", wr_during_rd, 0);

    do_dump(1'b0, 1'b0);
    check_dump("empty", 1'b1);

    for (int i = 0; i < 8; i++) if (vec[i].phase == 0) wr(vec[i].bank, vec[i].addr, vec[i].data);
    check("p0_wr_seen", wr_seen, 3'b101);
    do_dump(1'b0, 1'b0);
    check_dump("p0", 1'b1);
    check_table(0);

    for (int i = 0; i < 8; i++) if (vec[i].phase == 1) wr(vec[i].bank, vec[i].addr, vec[i].data);
    // all three channels in one cycle
    we_a = 1; we_b = 1; we_c = 1; waddr_a = 6'd1; waddr_b = 6'd1; waddr_c = 6'd1;
    wdata_a = 128'h1; wdata_b = 128'h2; wdata_c = 128'h3;
    @(posedge clk); #1;
    we_a = 0; we_b = 0; we_c = 0;
    exp_mem[1] = 128'h1; exp_mem[65] = 128'h2; exp_mem[129] = 128'h3;
    exp_vld[1] = 1; exp_vld[65] = 1; exp_vld[129] = 1;
    check("p1_wr_seen", wr_seen, 3'b111);
    do_dump(1'b0, 1'b0);
    check_dump("p1", 1'b1);
    check_table(1);
    check("simul_a1", got[4], 32'h1);
    check("simul_b1", got[260], 32'h2);
    check("simul_c1", got[516], 32'h3);
    for (int i = 0; i < 768; i++) ref_beats[i] = got[i];

    do_dump(1'b1, 1'b0);
    check_dump("rnd", 1'b0);
    diffs = 0;
    for (int i = 0; i < 768; i++) if (got[i] !== ref_beats[i]) diffs++;
    check("rnd_vs_ready_high", diffs, 0);
    check("rnd_wr_during_rd", wr_during_rd, 0);

    // Mid-dump: ignored start/clr at cycle 300, B5 after its line passed, C2 on its own FETCH edge.
    fork
      do_dump(1'b0, 1'b0);
      begin
        @(posedge clk);
        repeat (300) @(posedge clk);
        #2 rd_start = 1'b1; clr = 1'b1;
        @(posedge clk);
        #2 rd_start = 1'b0; clr = 1'b0;
        repeat (199) @(posedge clk);
        #2 we_b = 1'b1; waddr_b = 6'd5; wdata_b = vec[6].data;
        @(posedge clk);
        #2 we_b = 1'b0;
        repeat (149) @(posedge clk);
        #2 we_c = 1'b1; waddr_c = 6'd2; wdata_c = vec[7].data;
        @(posedge clk);
        #2 we_c = 1'b0;
      end
    join
    check_dump("mid", 1'b1);
    check("mid_wr_during_rd", wr_during_rd, 1);
    check("mid_wr_seen", wr_seen, 3'b111);
    check("mid_b5_not_yet", got[276], 32'h0);
    check("mid_c2_read_first", got[520], 32'h0);
    exp_mem[69] = vec[6].data; exp_vld[69] = 1;
    exp_mem[130] = vec[7].data; exp_vld[130] = 1;
    do_dump(1'b0, 1'b0);
    check_dump("after_mid", 1'b1);
    check_table(2);

    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_wr_during_rd", wr_during_rd, 0);
    check("clr_wr_seen", wr_seen, 3'b000);
    model_clear();
    do_dump(1'b0, 1'b0);
    check_dump("clr", 1'b1);

    wr(0, 3, 128'hABC);
    model_clear();
    do_dump(1'b0, 1'b1);
    check_dump("clr_start", 1'b1);

    wr(0, 0, 128'h5);
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 300 && cyc < 2000) begin
      if (rd_valid && rd_ready) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_handshakes", hs, 300);
    #2 srst = 1'b1;
    #1;
    check("rst_mid_rd_valid", rd_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_last", rd_last, 0);
    @(posedge clk); #1;
    srst = 1'b0;
    model_clear();
    do_dump(1'b0, 1'b0);
    check_dump("post_rst", 1'b1);

    tpu_done = 1'b1;
`ifdef AUTO_DUMP_EN
    n = 0;
    while (!rd_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("auto_latency", n, 3);
    hs = 0; cyc = 0;
    while (busy && cyc < 2000) begin
      if (rd_valid && rd_ready) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    check("auto_beats", hs, 768);
    n = 0;
    repeat (1200) begin @(posedge clk); #1; if (busy) n++; end
    check("auto_no_second_dump", n, 0);
`else
    n = 0;
    repeat (50) begin @(posedge clk); #1; if (busy) n++; end
    check("no_auto_dump", n, 0);
`endif
    tpu_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_result_collector.md
# tpu_result_collector

Capture-side responder for the TPU core's three result-write channels (A, B, C). Each write is stored in a 64-entry x 128-bit bank per channel, and each written address is tracked in a valid bitmap. On request, the block streams all three banks out over a 32-bit valid/ready port, so an FPGA top level can forward results to a UART, ILA or LED logic instead of leaving the write ports dangling.

## Interface

Parameters:
- ADDR_W, 6, bank address width (depth = 2^ADDR_W = 64)
- DATA_W, 128, width of one TPU result line
- BEAT_W, 32, readout beat width; DATA_W must be an integer multiple of BEAT_W

Ports:
- clk  in  1  single clock
- srst  in  1  reset: asynchronous, active-high
- sram_write_enable_a0 / _b0 / _c0  in  1 each  per-channel write strobe from TPU core
- sram_waddr_a / _b / _c  in  ADDR_W each  write address
- sram_wdata_a / _b / _c  in  DATA_W each  write data
- tpu_done  in  1  TPU completion level
- rd_start  in  1  request a full dump; sampled only in IDLE
- clr  in  1  clear valid bitmaps and sticky flags; sampled only in IDLE
- rd_valid  out  1  beat valid
- rd_ready  in  1  sink accepts beat
- rd_data  out  BEAT_W  beat payload
- rd_last  out  1  final beat of dump
- busy  out  1  dump in progress
- wr_seen  out  3  sticky per-bank "any write received" flags, bit0 = A
- wr_during_rd  out  1  sticky: a write arrived while busy

## Operation

- Capture is always enabled. A strobe on channel X writes wdata_X to bank X[waddr_X] and sets valid_X[waddr_X] and wr_seen[X]. All three channels may write in the same cycle.
- If the same address is written twice, the later write wins.
- FSM states: IDLE, FETCH, SEND.
  - IDLE -> FETCH on a start trigger. The line pointer is set to bank A, address 0, beat 0.
  - FETCH: one cycle. Bank[ptr] is read into the line register. If the valid bit is clear, the line register loads 0.
  - SEND: presents beat k = line[k*BEAT_W +: BEAT_W], LSB beat first.
    - On rd_valid & rd_ready, if k < DATA_W/BEAT_W-1, advance k.
    - Otherwise, advance the address. If the address wraps from 63, move to the next bank (A->B->C).
    - After the beat k = DATA_W/BEAT_W-1 of C[63] is accepted, go to IDLE; otherwise go to FETCH.
- A dump always covers 3 x 64 lines x 4 beats = 768 beats. Unwritten lines stream as zeros.
- Writes during a dump:
  - The write is still stored and wr_during_rd is set.
  - A write to the line being fetched in the same cycle yields the old contents (read-first).
- clr in IDLE clears all valid bits, wr_seen and wr_during_rd next cycle. Bank contents are not cleared.
- rd_start and clr asserted together in IDLE: clr takes effect and the dump starts from the cleared state, so all beats are 0 unless writes land first.
- rd_start, clr and a start trigger while busy are ignored.

## Timing

- Reset values: state IDLE; rd_valid, rd_last, busy, wr_during_rd = 0; rd_data = 0; wr_seen = 3'b000; valid bitmaps = 0.
- Start latency:
  - rd_start is high at edge n; busy = 1 from cycle n+1 (FETCH).
  - The first rd_valid is in cycle n+2.
- rd_valid is high only in SEND.
- Handshake rules:
  - rd_data and rd_last are held stable while rd_valid & !rd_ready.
  - rd_valid never drops without a handshake.
- Throughput: each line costs 1 FETCH cycle plus 4 beats, giving a minimum of 960 cycles per dump with rd_ready tied high.
- rd_last is high only together with the final beat.
- busy falls the cycle after the final handshake.
- Write-to-readable latency: a write at edge n is visible to a FETCH at edge n+1 or later.
- Reset asserted mid-dump: the state aborts immediately (asynchronous) and all outputs return to their reset values. Stored bank contents are undefined and valid bits are cleared.

## Configuration

- AUTO_DUMP_EN defined: a rising edge of tpu_done (registered 0->1) seen in IDLE acts as a start trigger, identical to rd_start. A rising edge seen while busy is ignored and is not queued.
- AUTO_DUMP_EN undefined: tpu_done is unused; only rd_start starts a dump.

## Test plan

- Reset, then check all outputs: rd_valid = 0, busy = 0, wr_seen = 0; rd_start with no writes -> 768 beats, all 0, rd_last only on beat 768, busy low 1 cycle after.
- Write A[0] = 128'h0000000400000003_0000000200000001, C[63] = all-ones -> beats 1..4 = 1,2,3,4; beats 765..768 = 32'hFFFFFFFF; wr_seen = 3'b101.
- Toggle rd_ready at random (50%) -> identical beat sequence to the ready-high run; rd_data stable during stalls; total 768 handshakes.
- Write B[5] during a dump -> wr_during_rd = 1; the data appears in the next dump; clr in IDLE -> wr_during_rd = 0, next dump all zeros.
- Assert srst while streaming beat 300 -> rd_valid, busy and rd_last fall to 0 immediately; rd_start afterward -> a fresh 768-beat dump of zeros.
- With AUTO_DUMP_EN: raise tpu_done -> dump starts without rd_start, first rd_valid 3 cycles after the rising edge (1 cycle edge register + 2 start latency); tpu_done held high -> no second dump. Without the macro -> no dump.
